// File: rtl/calc_alu_seq.sv
// rtl/calc_alu_seq.sv - multi-cycle add/sub/multiply/divide sequencer for the calculator datapath
module calc_alu_seq #(
    parameter int W   = 14,
    parameter int MAX = 9999
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         clr,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [W-1:0] rem,
    output logic         neg,
    output logic         err
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]   MAX_W  = W'(MAX);
    localparam logic [W:0]     MAX_W1 = (W + 1)'(MAX);
    localparam logic [2*W-1:0] MAX_W2 = (2 * W)'(MAX);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, FIN} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   opa;      // operand a; doubles as dividend/quotient shift register
    logic [W-1:0]   opb;      // operand b; shifted right as the multiplier
    logic [1:0]     opc;
    logic [2*W-1:0] mcand;    // multiplicand, shifted left one place per step
    logic [2*W-1:0] acc;      // product accumulator
    logic [W:0]     rem_r;    // partial remainder
    logic [CW-1:0]  cnt;

    logic [W:0]     sum;
    logic           op_bad;
    logic           last;
    logic [2*W-1:0] prod_nxt;
    logic [W+1:0]   trial;
    logic [W:0]     diff;
    logic           fits;
    logic [W:0]     rem_nxt;
    logic [W-1:0]   quo_nxt;

    // Per-cycle arithmetic: add, one shift-add step, one restoring-divide step
    always_comb begin
        sum      = {1'b0, opa} + {1'b0, opb};
        op_bad   = (opa > MAX_W) || (opb > MAX_W);
        last     = (cnt == CW'(1));
        prod_nxt = acc + (opb[0] ? mcand : '0);
        trial    = {rem_r, opa[W-1]};
        fits     = (trial >= {2'b00, opb});
        diff     = trial[W:0] - {1'b0, opb};
        rem_nxt  = fits ? diff : trial[W:0];
        quo_nxt  = {opa[W-2:0], fits};
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; clr aborts from any state
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = EXEC;
                EXEC: begin
                    if (op_bad || opc == OP_ADD || opc == OP_SUB ||
                        (opc == OP_DIV && opb == '0))
                        state_nxt = FIN;
                    else
                        state_nxt = ITER;
                end
                ITER: if (last) state_nxt = FIN;
                FIN:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == EXEC) || (state == ITER);
        done = (state == FIN);
    end

    // Operand latches, iteration datapath and held result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opa <= '0; opb <= '0; opc <= '0;
            mcand <= '0; acc <= '0; rem_r <= '0; cnt <= '0;
            result <= '0; rem <= '0; neg <= 1'b0; err <= 1'b0;
        end else if (clr) begin
            opa <= '0; opb <= '0; opc <= '0;
            mcand <= '0; acc <= '0; rem_r <= '0; cnt <= '0;
            result <= '0; rem <= '0; neg <= 1'b0; err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa    <= a;
                        opb    <= b;
                        opc    <= op;
                        mcand  <= {{W{1'b0}}, a};
                        acc    <= '0;
                        rem_r  <= '0;
                        result <= '0;
                        rem    <= '0;
                        neg    <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                EXEC: begin
                    cnt <= CW'(W);
                    if (op_bad) begin
                        err <= 1'b1;
                    end else begin
                        case (opc)
                            OP_ADD: begin
                                result <= sum[W-1:0];
                                err    <= (sum > MAX_W1);
                            end
                            OP_SUB: begin
                                if (opa >= opb) begin
                                    result <= opa - opb;
                                end else begin
                                    result <= opb - opa;
                                    neg    <= 1'b1;
                                end
                            end
                            OP_DIV: if (opb == '0) err <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    cnt <= cnt - CW'(1);
                    if (opc == OP_MUL) begin
                        acc   <= prod_nxt;
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                        if (last) begin
                            result <= prod_nxt[W-1:0];
                            // range check uses the full product, not the truncated field
                            err    <= (prod_nxt > MAX_W2);
                        end
                    end else begin
                        rem_r <= rem_nxt;
                        opa   <= quo_nxt;
                        if (last) begin
                            result <= quo_nxt;
                            rem    <= rem_nxt[W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu_seq.sv
// tb/tb_calc_alu_seq.sv - self-checking bench for calc_alu_seq
module tb_calc_alu_seq;

    localparam int W   = 14;
    localparam int MAX = 9999;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         clr;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] rem;
    logic         neg;
    logic         err;

    int n_checks = 0;
    int n_fails  = 0;

    calc_alu_seq #(.W(W), .MAX(MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .clr    (clr),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rem    (rem),
        .neg    (neg),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results straight from arithmetic on the operand values
    task automatic model(input logic [1:0] o, input int x, input int y,
                         output int res, output int rm, output int ng,
                         output int er, output int lat);
        int s;
        res = 0; rm = 0; ng = 0; er = 0; lat = 2;
        if (x > MAX || y > MAX) begin
            er = 1;
        end else begin
            case (o)
                2'd0: begin
                    s = x + y;
                    res = s % (1 << W);
                    er = (s > MAX) ? 1 : 0;
                end
                2'd1: begin
                    if (x >= y) res = x - y;
                    else begin res = y - x; ng = 1; end
                end
                2'd2: begin
                    s = x * y;
                    res = s % (1 << W);
                    er = (s > MAX) ? 1 : 0;
                    lat = W + 2;
                end
                default: begin
                    if (y == 0) er = 1;
                    else begin res = x / y; rm = x % y; lat = W + 2; end
                end
            endcase
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input int x, input int y);
        int res, rm, ng, er, lat, cyc;
        logic [31:0] xv, yv;
        model(o, x, y, res, rm, ng, er, lat);
        xv = x;
        yv = y;
        op = o; a = xv[W-1:0]; b = yv[W-1:0]; start = 1'b1;
        tick();
        start = 1'b0;
        // disturb the inputs mid-operation; the latched copies must be used
        op = o + 2'd1;
        a  = W'($urandom);
        b  = W'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            check({tag, " busy"}, busy, 1);
            tick();
            cyc++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy@done"}, busy, 0);
        check({tag, " result"}, result, res);
        check({tag, " rem"}, rem, rm);
        check({tag, " neg"}, neg, ng);
        check({tag, " err"}, err, er);
        tick();
        check({tag, " done pulse"}, done, 0);
        check({tag, " result hold"}, result, res);
        check({tag, " err hold"}, err, er);
    endtask

    initial begin
        int dcount;
        int x, y;
        logic [1:0] o;

        resetn = 1'b0; start = 1'b0; clr = 1'b0; op = '0; a = '0; b = '0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset rem", rem, 0);
        check("reset neg", neg, 0);
        check("reset err", err, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();

        run_op("add 1234+4321", 2'd0, 1234, 4321);
        run_op("add 9999+1", 2'd0, 9999, 1);
        run_op("sub 12-345", 2'd1, 12, 345);
        run_op("sub 345-12", 2'd1, 345, 12);
        run_op("mul 99*101", 2'd2, 99, 101);
        run_op("mul 100*100", 2'd2, 100, 100);
        run_op("div 9999/7", 2'd3, 9999, 7);
        run_op("div by 0", 2'd3, 1234, 0);
        run_op("add bad a", 2'd0, 10000, 1);
        run_op("mul bad b", 2'd2, 3, 16383);
        run_op("div 0/9999", 2'd3, 0, 9999);
        run_op("mul 9999*9999", 2'd2, 9999, 9999);

        // clr after completion clears held outputs
        run_op("sub pre-clr", 2'd1, 5, 9);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr result", result, 0);
        check("clr neg", neg, 0);

        // abort a multiply with clr in cycle 5
        op = 2'd2; a = 14'd100; b = 14'd100; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort result", result, 0);
        check("abort err", err, 0);
        dcount = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("abort no done", dcount, 0);
        run_op("after abort", 2'd2, 37, 41);

        // clr and start together in IDLE: start dropped
        op = 2'd0; a = 14'd1; b = 14'd2; start = 1'b1; clr = 1'b1;
        tick();
        start = 1'b0; clr = 1'b0;
        check("clr+start busy", busy, 0);
        tick();
        check("clr+start done", done, 0);

        // second start while busy is ignored
        op = 2'd2; a = 14'd99; b = 14'd101; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        op = 2'd0; a = 14'd1; b = 14'd1; start = 1'b1;
        tick();
        start = 1'b0;
        dcount = 0;
        repeat (30) begin
            if (done === 1'b1) begin
                dcount++;
                check("restart result", result, 9999);
            end
            tick();
        end
        check("restart done count", dcount, 1);

        // async reset mid-divide
        op = 2'd3; a = 14'd9999; b = 14'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst result", result, 0);
        check("async rst rem", rem, 0);
        tick();
        resetn = 1'b1;
        dcount = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("rst no done", dcount, 0);

        // randomized operations against the reference
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10000, 16383))
                                            : int'($urandom_range(0, 9999));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                            : int'($urandom_range(0, 9999));
            if ($urandom_range(0, 9) == 0) y = int'($urandom_range(10000, 16383));
            run_op($sformatf("rand%0d op%0d %0d,%0d", i, o, x, y), o, x, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Multi-cycle arithmetic sequencer for the 4-digit calculator datapath. It accepts operands and an operator code from the calculator control FSM on a one-cycle start pulse and sequences add, subtract, shift-add multiply or restoring divide over the operands. It returns the result with a one-cycle done pulse, plus sign, remainder and error flags for the display path. It sits between the operand/operator save registers and the result register.

Parameters:
W, 14, operand/result width in bits (covers 0..9999)
MAX, 9999, largest displayable magnitude; larger results flag err

Ports:
clk  in  1  clock, rising edge
resetn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request; sampled only in IDLE
clr  in  1  synchronous abort (CLEAR key); priority over everything except reset
op  in  2  00 add, 01 sub, 10 mul, 11 div; latched at start
a  in  W  first operand; latched at start
b  in  W  second operand; latched at start
busy  out  1  high from the cycle after an accepted start until the cycle before done
done  out  1  one-cycle pulse; outputs are valid from this cycle on
result  out  W  magnitude of the result (quotient for div)
rem  out  W  remainder for div, 0 for other ops
neg  out  1  sub result negative (a<b); result holds b-a
err  out  1  overflow (>MAX), operand >MAX, or divide by zero

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, neg, err = 0; result, rem = 0; internal accumulators cleared. Reset during any operation aborts it and no done is produced.
- States: IDLE, EXEC, ITER, FIN.
- IDLE: on start=1, latch a, b, op, clear result/rem/neg/err, go to EXEC. start outside IDLE is ignored, with no queuing.
- EXEC (busy=1), one cycle:
  - If a>MAX or b>MAX: set err, go to FIN.
  - add: sum = a+b in W+1 bits; result = sum; err = (sum>MAX); go to FIN.
  - sub: if a>=b, result=a-b and neg=0; otherwise result=b-a and neg=1; go to FIN.
  - div with b==0: err=1, result=0, rem=0; go to FIN.
  - mul/div otherwise: load the iteration counter with W, go to ITER.
- ITER (busy=1), exactly W cycles, counter decrements to 0:
  - mul: 2W-bit product accumulator, one shift-add step per cycle (LSB-first on b).
  - div: restoring division, one quotient bit per cycle MSB-first; remainder register W+1 bits.
  - After the last iteration go to FIN.
  - For mul: result = product[W-1:0]; err = (product>MAX). The full product is compared, not the truncated one.
- FIN: busy=0, done=1 for this cycle only; next state is IDLE. result, rem, neg and err hold until the next accepted start, clr or reset.
- Latency, counting the start cycle as 0:
  - add/sub/error short path: done in cycle 2.
  - mul/div: done in cycle W+2 (16 with the default).
  - busy is high in cycles 1 .. latency-1.
- clr=1 in any state: next state IDLE; busy, done, neg, err = 0; result, rem = 0. An in-flight operation is dropped with no done. If clr and start are high together in IDLE, clr wins and the start is dropped.
- Width rules: operands are unsigned binary. Internal sum is W+1 bits and product is 2W bits. No wrap-around reaches result without err=1.
- If op changes while busy, the operation already in progress is unaffected because op is latched.

Test Plan:
- Add: start, op=00, a=1234, b=4321 -> busy in cycle 1, done in cycle 2, result=5555, neg=0, err=0; 9999+1 -> err=1.
- Sub: op=01, a=12, b=345 -> done in cycle 2, result=333, neg=1, err=0; 345-12 -> result=333, neg=0.
- Mul: op=10, a=99, b=101 -> done in cycle 16, result=9999, err=0; 100*100 -> done in cycle 16, err=1.
- Div: op=11, a=9999, b=7 -> done in cycle 16, result=1428, rem=3; b=0 -> done in cycle 2, err=1, result=0.
- Abort: start mul, assert clr in cycle 5 -> IDLE next cycle, all outputs 0, no done pulse; a new start then completes normally.
- Protocol: a second start while busy is ignored (only one done, for the first op). With resetn=0 mid-divide, outputs go to 0 immediately (async) and there is no done after release.
